// File: rtl/mmio_port_responder.sv
// MMIO responder: 16-byte window with output port, synced input port, edge capture and IRQ.
// Latency: Ready pulses WAIT_STATES+1 cycles after Hit is first sampled; ReadData is valid with it.
// Backpressure: none; the initiator holds the request until Ready, and the FSM accepts one access at a time.
module mmio_port_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [31:0] OUT_RESET   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        Hit,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        Irq
);

    localparam logic [1:0] OFF_PORT_OUT    = 2'd0;
    localparam logic [1:0] OFF_PORT_IN     = 2'd1;
    localparam logic [1:0] OFF_EDGE_STATUS = 2'd2;
    localparam logic [1:0] OFF_EDGE_MASK   = 2'd3;

    localparam int unsigned WS_M1    = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  CNT_INIT = WS_M1[3:0];

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    typedef struct packed {
        logic [1:0]  offset;
        logic        isWrite;
        logic [31:0] data;
    } req_t;

    state_t      state;
    logic [3:0]  cnt;
    req_t        req;
    req_t        reqIn;

    logic [7:0]  sync1;
    logic [7:0]  sync2;
    logic [7:0]  edgeStatus;
    logic [7:0]  edgeMask;
    logic [7:0]  statusNext;
    logic [7:0]  maskNext;
    logic [7:0]  clrBits;

    logic        commit;
    logic [1:0]  readOffset;
    logic        readIsWrite;
    logic [31:0] readValue;
    logic [31:0] readWord;

    logic        unusedAddrBits;

    assign unusedAddrBits = ^Address[1:0];

    assign Hit = (Address[31:4] == BASE_ADDR[31:4]) && (MemRead || MemWrite);

    always_comb begin
        reqIn.offset  = Address[3:2];
        reqIn.isWrite = MemWrite;
        reqIn.data    = WriteData;
    end

    // With zero wait states ACK is entered straight from IDLE, before the request is latched.
    assign readOffset  = (state == S_IDLE) ? Address[3:2] : req.offset;
    assign readIsWrite = (state == S_IDLE) ? MemWrite     : req.isWrite;

    always_comb begin
        readValue = 32'h0;
        case (readOffset)
            OFF_PORT_OUT:    readValue = PortOut;
            OFF_PORT_IN:     readValue = {24'h0, sync2};
            OFF_EDGE_STATUS: readValue = {24'h0, edgeStatus};
            OFF_EDGE_MASK:   readValue = {24'h0, edgeMask};
            default:         readValue = 32'h0;
        endcase
    end

    assign readWord = readIsWrite ? 32'h0 : readValue;

    assign commit = (state == S_ACK) && req.isWrite;

    assign clrBits  = (commit && req.offset == OFF_EDGE_STATUS) ? req.data[7:0] : 8'h00;
    // A new edge in the same cycle as a clear of that bit keeps the bit set.
    assign statusNext = (edgeStatus & ~clrBits) | (sync1 & ~sync2);
    assign maskNext   = (commit && req.offset == OFF_EDGE_MASK) ? req.data[7:0] : edgeMask;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= 4'd0;
            req      <= '0;
            Ready    <= 1'b0;
            ReadData <= 32'h0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Hit) begin
                        req <= reqIn;
                        if (WAIT_STATES > 0) begin
                            state <= S_WAIT;
                            cnt   <= CNT_INIT;
                        end else begin
                            state    <= S_ACK;
                            Ready    <= 1'b1;
                            ReadData <= readWord;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt == 4'd0) begin
                        state    <= S_ACK;
                        Ready    <= 1'b1;
                        ReadData <= readWord;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_ACK: begin
                    state    <= S_IDLE;
                    Ready    <= 1'b0;
                    ReadData <= 32'h0;
                end
                default: begin
                    state    <= S_IDLE;
                    Ready    <= 1'b0;
                    ReadData <= 32'h0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1      <= 8'h00;
            sync2      <= 8'h00;
            edgeStatus <= 8'h00;
            edgeMask   <= 8'h00;
            Irq        <= 1'b0;
            PortOut    <= OUT_RESET;
        end else begin
            sync1      <= PortIn;
            sync2      <= sync1;
            edgeStatus <= statusNext;
            edgeMask   <= maskNext;
            Irq        <= |(statusNext & maskNext);
            if (commit && req.offset == OFF_PORT_OUT) begin
                PortOut <= req.data;
            end
        end
    end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Bench for mmio_port_responder: directed accesses, scoreboard on Ready/ReadData, direct checks on ports.
module tb_mmio_port_responder;

    localparam logic [31:0] RST3 = 32'hC0DE_0001;

    logic        clk;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] ReadData;
    logic        Ready;
    logic        Hit;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    logic        Irq;

    logic        rst3;
    logic [31:0] Address3;
    logic [31:0] WriteData3;
    logic        MemWrite3;
    logic        MemRead3;
    logic [31:0] ReadData3;
    logic        Ready3;
    logic        Hit3;
    logic [7:0]  PortIn3;
    logic [31:0] PortOut3;
    logic        Irq3;

    int          nCompared = 0;
    int          nMismatch = 0;
    logic [31:0] expQ[$];

    mmio_port_responder #(
        .BASE_ADDR  (32'h1001_0000),
        .WAIT_STATES(1),
        .OUT_RESET  (32'h0000_0000)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .Address  (Address),
        .WriteData(WriteData),
        .MemWrite (MemWrite),
        .MemRead  (MemRead),
        .ReadData (ReadData),
        .Ready    (Ready),
        .Hit      (Hit),
        .PortIn   (PortIn),
        .PortOut  (PortOut),
        .Irq      (Irq)
    );

    mmio_port_responder #(
        .BASE_ADDR  (32'h1001_0000),
        .WAIT_STATES(3),
        .OUT_RESET  (RST3)
    ) u_dut3 (
        .clk      (clk),
        .reset    (rst3),
        .Address  (Address3),
        .WriteData(WriteData3),
        .MemWrite (MemWrite3),
        .MemRead  (MemRead3),
        .ReadData (ReadData3),
        .Ready    (Ready3),
        .Hit      (Hit3),
        .PortIn   (PortIn3),
        .PortOut  (PortOut3),
        .Irq      (Irq3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatch++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every Ready pulse consumes one expected ReadData.
    always @(negedge clk) begin
        if (Ready) begin
            if (expQ.size() == 0) begin
                nCompared++;
                nMismatch++;
                $display("FAIL unexpected_ready: got ReadData %h, want no response", ReadData);
            end else begin
                check("readdata", ReadData, expQ.pop_front());
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic [31:0] wd,
                        input logic wr, input logic rd, input logic [31:0] expRd);
        int n;
        Address   = addr;
        WriteData = wd;
        MemWrite  = wr;
        MemRead   = rd;
        expQ.push_back(expRd);
        n = 0;
        do begin
            tick();
            n++;
        end while (!Ready && n < 20);
        check("latency", 32'(n), 32'd2);
        if (!Ready) void'(expQ.pop_back());
        MemWrite  = 1'b0;
        MemRead   = 1'b0;
        Address   = 32'h0;
        tick();
    endtask

    initial begin
        int bad;
        int n;
        reset = 1'b0; Address = 32'h0; WriteData = 32'h0; MemWrite = 1'b0; MemRead = 1'b0; PortIn = 8'h00;
        rst3 = 1'b0; Address3 = 32'h0; WriteData3 = 32'h0; MemWrite3 = 1'b0; MemRead3 = 1'b0; PortIn3 = 8'h00;

        // Reset state with input toggling
        for (int i = 0; i < 6; i++) begin
            PortIn = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
        end
        check("rst_portout", PortOut, 32'h0);
        check("rst_ready", 32'(Ready), 32'h0);
        check("rst_irq", 32'(Irq), 32'h0);
        check("rst_readdata", ReadData, 32'h0);
        check("rst3_portout", PortOut3, RST3);

        PortIn = 8'hA5;
        reset  = 1'b1;
        tick(); tick(); tick();
        xfer(32'h1001_0004, 32'h0, 1'b0, 1'b1, 32'h0000_00A5);
        check("irq_masked", 32'(Irq), 32'h0);

        // Write latency and commit point
        Address = 32'h1001_0000; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
        expQ.push_back(32'h0);
        tick();
        check("wr_wait_ready", 32'(Ready), 32'h0);
        check("wr_wait_portout", PortOut, 32'h0);
        tick();
        check("wr_ack_ready", 32'(Ready), 32'h1);
        check("wr_ack_portout", PortOut, 32'h0);
        MemWrite = 1'b0; Address = 32'h0;
        tick();
        check("wr_commit_portout", PortOut, 32'hDEAD_BEEF);
        check("wr_ready_pulse", 32'(Ready), 32'h0);
        xfer(32'h1001_0000, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // Edge capture, mask, IRQ, W1C
        xfer(32'h1001_0008, 32'hFF, 1'b1, 1'b0, 32'h0);
        PortIn = 8'h00;
        tick(); tick(); tick();
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h0);
        xfer(32'h1001_000C, 32'h01, 1'b1, 1'b0, 32'h0);
        check("irq_before_edge", 32'(Irq), 32'h0);
        PortIn = 8'h03;
        tick(); tick(); tick();
        check("irq_after_edge", 32'(Irq), 32'h1);
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h03);
        xfer(32'h1001_0008, 32'h01, 1'b1, 1'b0, 32'h0);
        check("irq_after_w1c", 32'(Irq), 32'h0);
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h02);

        // Set-versus-clear race on bit 0
        PortIn = 8'h00;
        tick(); tick(); tick();
        xfer(32'h1001_0008, 32'hFF, 1'b1, 1'b0, 32'h0);
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h0);
        check("irq_cleared", 32'(Irq), 32'h0);
        Address = 32'h1001_0008; WriteData = 32'h01; MemWrite = 1'b1;
        expQ.push_back(32'h0);
        tick();
        PortIn = 8'h01;
        tick();
        check("race_ready", 32'(Ready), 32'h1);
        MemWrite = 1'b0; Address = 32'h0;
        tick();
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h01);
        check("race_irq", 32'(Irq), 32'h1);

        // Window decode
        Address = 32'h1001_000C;
        #1 check("hit_no_req", 32'(Hit), 32'h0);
        MemRead = 1'b1;
        #1 check("hit_in_window", 32'(Hit), 32'h1);
        MemRead = 1'b0; Address = 32'h0;
        tick();
        Address = 32'h1001_0010; MemRead = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (Hit || Ready) bad++;
            tick();
        end
        check("out_of_window", 32'(bad), 32'h0);
        MemRead = 1'b0; Address = 32'h0;
        tick();

        // Read+write together, write to PORT_IN, unused upper bits
        xfer(32'h1001_000C, 32'hF0, 1'b1, 1'b1, 32'h0);
        check("irq_mask_f0", 32'(Irq), 32'h0);
        xfer(32'h1001_000C, 32'h0, 1'b0, 1'b1, 32'h0000_00F0);
        xfer(32'h1001_0004, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        check("portin_write_portout", PortOut, 32'hDEAD_BEEF);
        xfer(32'h1001_0004, 32'h0, 1'b0, 1'b1, 32'h01);
        xfer(32'h1001_0008, 32'h0, 1'b0, 1'b1, 32'h01);
        xfer(32'h1001_000C, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h0);
        check("irq_mask_ff", 32'(Irq), 32'h1);
        xfer(32'h1001_000C, 32'h0, 1'b0, 1'b1, 32'h0000_00FF);

        // Request dropped during WAIT still completes
        Address = 32'h1001_0000; MemRead = 1'b1;
        expQ.push_back(32'hDEAD_BEEF);
        tick();
        MemRead = 1'b0; Address = 32'h0;
        n = 0;
        while (!Ready && n < 10) begin
            tick();
            n++;
        end
        check("drop_ready", 32'(Ready), 32'h1);
        tick();

        // Abort by reset in WAIT on the 3-wait-state instance
        rst3 = 1'b1;
        tick(); tick();
        Address3 = 32'h1001_0000; WriteData3 = 32'h1234_5678; MemWrite3 = 1'b1;
        tick(); tick();
        check("abort_wait_ready", 32'(Ready3), 32'h0);
        rst3 = 1'b0;
        #1 check("abort_portout", PortOut3, RST3);
        MemWrite3 = 1'b0; Address3 = 32'h0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (Ready3) bad++;
        end
        check("abort_no_ready", 32'(bad), 32'h0);
        rst3 = 1'b1;
        tick();
        check("abort_release_portout", PortOut3, RST3);
        Address3 = 32'h1001_0000; MemRead3 = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!Ready3 && n < 20);
        check("abort_read_latency", 32'(n), 32'd4);
        check("abort_read_data", ReadData3, RST3);
        MemRead3 = 1'b0; Address3 = 32'h0;
        tick();
        check("abort_ready_pulse", 32'(Ready3), 32'h0);

        tick(); tick();
        check("scoreboard_drained", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, want end of test");
        $fatal(1, "watchdog expired");
    end

endmodule
